// File: rtl/mips_dmem_mmio_if.sv
// Data-side bus between the single-cycle MIPS core and its data memory.
// The core drives the store strobe, byte address and store data.
// The memory returns load data combinationally in the same cycle.
interface mips_dmem_mmio_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output memwrite,
        output addr,
        output writedata,
        input  readdata
    );

    modport slave (
        input  memwrite,
        input  addr,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/mips_dmem_mmio.sv
// Data memory subsystem for the single-cycle MIPS core.
// Word-addressed RAM at the bottom of the address space, plus one MMIO page
// holding GPIO, a free-running timer with compare/interrupt, control and
// sticky status. Loads are combinational; stores commit on the rising edge.
module mips_dmem_mmio #(
    parameter int          RAM_WORDS = 64,
    parameter int          GPIO_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
    input  logic                clk,
    input  logic                reset,
    mips_dmem_mmio_if.slave     bus,
    output logic [GPIO_W-1:0]   gpio_out,
    input  logic [GPIO_W-1:0]   gpio_in,
    output logic                irq,
    output logic                bus_err
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    // MMIO register word offsets (addr[7:2])
    localparam logic [5:0] OFF_GPIO_OUT = 6'd0;
    localparam logic [5:0] OFF_GPIO_IN  = 6'd1;
    localparam logic [5:0] OFF_TIMER    = 6'd2;
    localparam logic [5:0] OFF_COMPARE  = 6'd3;
    localparam logic [5:0] OFF_CTRL     = 6'd4;
    localparam logic [5:0] OFF_STATUS   = 6'd5;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]       ram_r [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_out_r;
    logic [GPIO_W-1:0] gpio_meta_r;
    logic [GPIO_W-1:0] gpio_sync_r;
    logic [31:0]       timer_r;
    logic [31:0]       compare_r;
    logic [1:0]        ctrl_r;
    logic              match_r;
    logic              bus_err_r;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              ram_hit_s;
    logic              mmio_hit_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [5:0]        mmio_off_s;
    logic              off_valid_s;
    logic              wr_ram_s;
    logic              wr_gpio_s;
    logic              wr_timer_s;
    logic              wr_compare_s;
    logic              wr_ctrl_s;
    logic              wr_status_s;
    logic              err_set_s;
    logic              timer_hit_s;
    logic [31:0]       timer_next_s;
    logic              match_next_s;
    logic              bus_err_next_s;
    logic [31:0]       rdata_s;

    // Byte-lane bits and the unused middle of the MMIO page address are
    // don't-care: accesses are word-only and the page aliases every 256 B.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[15:8]};

    // Classify the current address and qualify the store strobe per target.
    always_comb begin
        ram_hit_s    = (bus.addr[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
        mmio_hit_s   = (!ram_hit_s) && (bus.addr[31:16] == MMIO_BASE[31:16]);
        ram_idx_s    = bus.addr[RAM_AW+1:2];
        mmio_off_s   = bus.addr[7:2];
        off_valid_s  = (mmio_off_s <= OFF_STATUS);

        wr_ram_s     = bus.memwrite && ram_hit_s;
        wr_gpio_s    = 1'b0;
        wr_timer_s   = 1'b0;
        wr_compare_s = 1'b0;
        wr_ctrl_s    = 1'b0;
        wr_status_s  = 1'b0;
        if (bus.memwrite && mmio_hit_s) begin
            case (mmio_off_s)
                OFF_GPIO_OUT: wr_gpio_s    = 1'b1;
                OFF_TIMER:    wr_timer_s   = 1'b1;
                OFF_COMPARE:  wr_compare_s = 1'b1;
                OFF_CTRL:     wr_ctrl_s    = 1'b1;
                OFF_STATUS:   wr_status_s  = 1'b1;
                default:      wr_gpio_s    = 1'b0;
            endcase
        end else begin
            wr_gpio_s = 1'b0;
        end

        // A store that lands nowhere, or on a hole in the MMIO page.
        // GPIO_IN is a real register, so a store to it is silently dropped.
        err_set_s = bus.memwrite && !ram_hit_s && !(mmio_hit_s && off_valid_s);
    end

    // Next timer value, compare match and sticky flag updates.
    always_comb begin
        // Matching looks at the timer before this edge's increment/load and
        // at the compare value already registered.
        timer_hit_s = ctrl_r[0] && (timer_r == compare_r);

        if (wr_timer_s) begin
            timer_next_s = bus.writedata;
        end else if (ctrl_r[0]) begin
            timer_next_s = timer_r + 32'd1;
        end else begin
            timer_next_s = timer_r;
        end

        // Write-1-to-clear first, then a coincident set overrides it.
        match_next_s   = match_r;
        bus_err_next_s = bus_err_r;
        if (wr_status_s) begin
            match_next_s   = match_r   & ~bus.writedata[0];
            bus_err_next_s = bus_err_r & ~bus.writedata[1];
        end else begin
            match_next_s   = match_r;
            bus_err_next_s = bus_err_r;
        end
        match_next_s   = match_next_s   | timer_hit_s;
        bus_err_next_s = bus_err_next_s | err_set_s;
    end

    // Word RAM: no reset on contents; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && wr_ram_s) begin
            ram_r[ram_idx_s] <= bus.writedata;
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_meta_r <= {GPIO_W{1'b0}};
            gpio_sync_r <= {GPIO_W{1'b0}};
        end else begin
            gpio_meta_r <= gpio_in;
            gpio_sync_r <= gpio_meta_r;
        end
    end

    // Software-visible MMIO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_r <= {GPIO_W{1'b0}};
            timer_r    <= 32'd0;
            compare_r  <= 32'hFFFF_FFFF;
            ctrl_r     <= 2'b00;
            match_r    <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            if (wr_gpio_s) begin
                gpio_out_r <= bus.writedata[GPIO_W-1:0];
            end
            if (wr_compare_s) begin
                compare_r <= bus.writedata;
            end
            if (wr_ctrl_s) begin
                ctrl_r <= bus.writedata[1:0];
            end
            timer_r   <= timer_next_s;
            match_r   <= match_next_s;
            bus_err_r <= bus_err_next_s;
        end
    end

    // Zero-latency load path: RAM word, MMIO register, or zero.
    always_comb begin
        rdata_s = 32'd0;
        if (ram_hit_s) begin
            rdata_s = ram_r[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (mmio_off_s)
                OFF_GPIO_OUT: rdata_s = {{(32-GPIO_W){1'b0}}, gpio_out_r};
                OFF_GPIO_IN:  rdata_s = {{(32-GPIO_W){1'b0}}, gpio_sync_r};
                OFF_TIMER:    rdata_s = timer_r;
                OFF_COMPARE:  rdata_s = compare_r;
                OFF_CTRL:     rdata_s = {30'd0, ctrl_r};
                OFF_STATUS:   rdata_s = {30'd0, bus_err_r, match_r};
                default:      rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.readdata = rdata_s;
    assign gpio_out     = gpio_out_r;
    assign bus_err      = bus_err_r;
    // Both terms are flops, so the interrupt adds no cycle of latency.
    assign irq          = match_r & ctrl_r[1];

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Self-checking bench for mips_dmem_mmio: directed vector table, hand-written
// timer/reset sequences and a randomized run against a behavioural model.
module tb_mips_dmem_mmio;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in;
    logic       irq;
    logic       bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_dmem_mmio_if bus ();

    mips_dmem_mmio #(
        .RAM_WORDS (64),
        .GPIO_W    (8),
        .MMIO_BASE (32'hFFFF0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq),
        .bus_err  (bus_err)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [64];
    bit          m_valid [64];
    logic [7:0]  m_gpio_out;
    logic [7:0]  m_gin_hist [$];   // last two sampled inputs, oldest first
    logic [31:0] m_timer;
    logic [31:0] m_cmp;
    logic [1:0]  m_ctrl;
    logic        m_match;
    logic        m_err;

    function automatic void model_reset();
        m_gpio_out = 8'h00;
        m_gin_hist = {8'h00, 8'h00};
        m_timer    = 32'd0;
        m_cmp      = 32'hFFFF_FFFF;
        m_ctrl     = 2'b00;
        m_match    = 1'b0;
        m_err      = 1'b0;
    endfunction

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'd256;
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return !is_ram(a) && (a[31:16] == 16'hFFFF);
    endfunction

    function automatic bit rd_known(input logic [31:0] a);
        if (is_ram(a)) return m_valid[a[7:2]];
        return 1'b1;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (is_ram(a)) return m_ram[a[7:2]];
        if (is_mmio(a)) begin
            case (a[7:2])
                6'd0: return {24'd0, m_gpio_out};
                6'd1: return {24'd0, m_gin_hist[0]};
                6'd2: return m_timer;
                6'd3: return m_cmp;
                6'd4: return {30'd0, m_ctrl};
                6'd5: return {30'd0, m_err, m_match};
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    function automatic void model_edge(input logic we, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [7:0] gin);
        logic [5:0]  off;
        logic        hit;
        logic        err_new;
        logic [31:0] nt;
        off     = a[7:2];
        hit     = m_ctrl[0] && (m_timer == m_cmp);
        err_new = we && !is_ram(a) && !(is_mmio(a) && off <= 6'd5);
        if (we && is_mmio(a) && off == 6'd2) nt = wd;
        else if (m_ctrl[0])                  nt = m_timer + 32'd1;
        else                                 nt = m_timer;
        if (we && is_ram(a)) begin
            m_ram[a[7:2]]   = wd;
            m_valid[a[7:2]] = 1'b1;
        end
        if (we && is_mmio(a)) begin
            if (off == 6'd0) m_gpio_out = wd[7:0];
            if (off == 6'd3) m_cmp = wd;
            if (off == 6'd4) m_ctrl = wd[1:0];
            if (off == 6'd5) begin
                m_match = m_match & ~wd[0];
                m_err   = m_err & ~wd[1];
            end
        end
        m_timer = nt;
        m_match = m_match | hit;
        m_err   = m_err | err_new;
        m_gin_hist.push_back(gin);
        void'(m_gin_hist.pop_front());
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, compare against the model, then clock.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] gin, output logic [31:0] rd,
                        output logic err_o, output logic irq_o);
        @(negedge clk);
        bus.memwrite  = we;
        bus.addr      = a;
        bus.writedata = wd;
        gpio_in       = gin;
        #1;
        rd    = bus.readdata;
        err_o = bus_err;
        irq_o = irq;
        if (rd_known(a)) check("model_readdata", rd, mread(a));
        check("model_gpio_out", {24'd0, gpio_out}, {24'd0, m_gpio_out});
        check("model_irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[1]});
        check("model_bus_err", {31'd0, bus_err}, {31'd0, m_err});
        @(posedge clk);
        model_edge(we, a, wd, gin);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [7:0]  gin;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        q;
        logic [31:0] a;
        logic [31:0] wd;
        logic [7:0]  gin;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00, 1'b0, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 8'h00, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 8'h00, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b1, 32'hFFFF_0000, 32'h0000_01A5, 8'h00, 1'b1, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b0, 32'hFFFF_0000, 32'h0000_0000, 8'h00, 1'b1, 32'h0000_00A5, 1'b0};
        tbl[5]  = '{1'b0, 32'hFFFF_0004, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0000, 1'b0};
        tbl[6]  = '{1'b0, 32'hFFFF_0004, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0000, 1'b0};
        tbl[7]  = '{1'b0, 32'hFFFF_0004, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_003C, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 8'h3C, 1'b1, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0000, 1'b1};
        tbl[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 8'h3C, 1'b1, 32'h1111_1111, 1'b1};
        tbl[11] = '{1'b0, 32'hFFFF_0014, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0002, 1'b1};
        tbl[12] = '{1'b1, 32'hFFFF_0014, 32'h0000_0002, 8'h3C, 1'b1, 32'h0000_0002, 1'b1};
        tbl[13] = '{1'b0, 32'hFFFF_0014, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0000, 1'b0};
        tbl[14] = '{1'b1, 32'hFFFF_0018, 32'h0000_0001, 8'h3C, 1'b1, 32'h0000_0000, 1'b0};
        tbl[15] = '{1'b1, 32'h0000_2000, 32'h0000_0005, 8'h3C, 1'b1, 32'h0000_0000, 1'b1};
        tbl[16] = '{1'b0, 32'hFFFF_0018, 32'h0000_0000, 8'h3C, 1'b1, 32'h0000_0000, 1'b1};
        tbl[17] = '{1'b1, 32'hFFFF_0014, 32'h0000_0002, 8'h3C, 1'b1, 32'h0000_0002, 1'b1};
        tbl[18] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 8'h3C, 1'b1, 32'hDEAD_BEEF, 1'b0};

        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        model_reset();

        // ---- reset state ----
        reset         = 1'b0;
        bus.memwrite  = 1'b0;
        bus.addr      = 32'hFFFF_000C;
        bus.writedata = 32'd0;
        gpio_in       = 8'h00;
        #12;
        check("rst_compare", bus.readdata, 32'hFFFF_FFFF);
        check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---- fill RAM so every later read has a known value ----
        for (int i = 0; i < 64; i++) begin
            wd = (i == 0) ? 32'h1111_1111 : $urandom;
            step(1'b1, 32'(i * 4), wd, 8'h00, rd, e, q);
        end

        // ---- directed vector table ----
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].gin, rd, e, q);
            if (tbl[i].chk) check($sformatf("tbl%0d_readdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_bus_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
        end
        check("gpio_out_a5", {24'd0, gpio_out}, 32'h0000_00A5);

        // ---- timer match and interrupt ----
        step(1'b1, 32'hFFFF_000C, 32'd5, 8'h3C, rd, e, q);
        step(1'b1, 32'hFFFF_0010, 32'd3, 8'h3C, rd, e, q);
        step(1'b1, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
            check($sformatf("timer_c%0d", i), rd, 32'(i));
            check($sformatf("irq_c%0d", i), {31'd0, q}, {31'd0, (i >= 6) ? 1'b1 : 1'b0});
        end
        step(1'b1, 32'hFFFF_0014, 32'd1, 8'h3C, rd, e, q);
        check("irq_before_w1c", {31'd0, q}, 32'd1);
        step(1'b0, 32'hFFFF_0014, 32'd0, 8'h3C, rd, e, q);
        check("irq_after_w1c", {31'd0, q}, 32'd0);
        check("status_after_w1c", rd, 32'd0);

        // ---- wrap and write priority ----
        step(1'b1, 32'hFFFF_0008, 32'hFFFF_FFFF, 8'h3C, rd, e, q);
        step(1'b0, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
        check("timer_max", rd, 32'hFFFF_FFFF);
        step(1'b0, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
        check("timer_wrap", rd, 32'd0);
        step(1'b1, 32'hFFFF_0008, 32'd100, 8'h3C, rd, e, q);
        step(1'b0, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
        check("timer_load_prio", rd, 32'd100);
        step(1'b0, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
        check("timer_after_load", rd, 32'd101);

        // ---- async reset with timer running, irq and bus_err set ----
        step(1'b1, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
        for (int i = 0; i < 7; i++) step(1'b0, 32'hFFFF_0008, 32'd0, 8'h3C, rd, e, q);
        step(1'b1, 32'hFFFF_0000, 32'h0000_005A, 8'h3C, rd, e, q);
        step(1'b1, 32'h0000_3000, 32'h0000_0001, 8'h3C, rd, e, q);
        @(negedge clk);
        bus.memwrite = 1'b0;
        bus.addr     = 32'hFFFF_0008;
        #1;
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        check("pre_rst_bus_err", {31'd0, bus_err}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_bus_err", {31'd0, bus_err}, 32'd0);
        check("arst_timer", bus.readdata, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 32'h0000_0010, 32'd0, 8'h3C, rd, e, q);
        check("ram_kept_after_rst", rd, 32'hDEAD_BEEF);

        // ---- randomized traffic against the model ----
        gin = 8'h3C;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                4, 5, 6: a = {16'hFFFF, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                              6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                default: a = $urandom;
            endcase
            wd = $urandom;
            if (is_mmio(a) && a[7:2] == 6'd3 && $urandom_range(0, 1) == 1)
                wd = m_timer + 32'($urandom_range(0, 4));
            if (is_mmio(a) && a[7:2] == 6'd4)
                wd = {30'd0, 2'b11} & (($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            if ($urandom_range(0, 7) == 0) gin = 8'($urandom);
            step(1'($urandom_range(0, 1)), a, wd, gin, rd, e, q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_dmem_mmio.md
Name: mips_dmem_mmio

Overview:
- Data-side memory subsystem directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, aluout (address) and writedata; returns readdata in the same cycle.
- Contains word-addressed data RAM plus a memory-mapped I/O page: GPIO out/in, free-running timer with compare, control/status with interrupt.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; must be a power of 2.
- GPIO_W, 8, width of GPIO output and input ports.
- MMIO_BASE, 32'hFFFF0000, base address of the MMIO page (64 KiB aligned).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  store strobe from core.
- addr  input  32  byte address (core aluout).
- writedata  input  32  store data.
- readdata  output  32  load data, combinational from addr.
- gpio_out  output  GPIO_W  GPIO output register.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- irq  output  1  timer interrupt request.
- bus_err  output  1  sticky illegal-access flag.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low.
- Reset (reset=0): gpio_out=0, gpio_in sync flops=0, timer=0, compare=32'hFFFFFFFF, ctrl=0, status=0, bus_err=0, irq=0. RAM contents are not reset.
- Address decode: addr[1:0] ignored (word access only).
  - RAM hit: addr < RAM_WORDS*4; index addr[log2(RAM_WORDS)+1:2].
  - MMIO hit: addr[31:16]==MMIO_BASE[31:16]; register offset addr[7:2].
  - Anything else is a miss.
- Reads: combinational, zero latency. RAM returns the stored word. Misses and undefined MMIO offsets return 0.
- Writes: take effect on the rising clk edge when memwrite=1. A read of the same address in the next cycle returns the new value.
- MMIO map (byte offsets):
  - 0x00 GPIO_OUT: RW, bits [GPIO_W-1:0]; upper bits read 0.
  - 0x04 GPIO_IN: RO; value after a 2-flop synchronizer, so an input change is visible 2 cycles later. Writes are ignored.
  - 0x08 TIMER: RW, 32-bit. Increments by 1 each cycle while ctrl[0]=1. Wraps 32'hFFFFFFFF -> 0. A write loads writedata and takes priority over the increment that cycle.
  - 0x0C COMPARE: RW, 32-bit.
  - 0x10 CTRL: RW; bit0 timer enable, bit1 irq enable; other bits read 0.
  - 0x14 STATUS: bit0 match flag (RW1C), bit1 bus_err mirror (RW1C); other bits read 0.
- Match: on each edge where ctrl[0]=1 and the pre-increment timer==COMPARE, STATUS[0] sets.
  - If a write-1-to-clear of bit0 coincides with a new match, set wins.
  - A write to COMPARE affects matching from the next cycle.
- irq = STATUS[0] & CTRL[1]. Registered-source combinational output; no extra latency.
- bus_err: sets on an edge where memwrite=1 and addr is a miss, or is an MMIO write to an undefined offset. It stays set until W1C of STATUS[1]; set wins on coincidence. Read misses do not set bus_err.
- reset asserted mid-operation clears all registers immediately, independent of clk. An in-flight write that edge is lost.

Test Plan:
- RAM: write 32'hDEADBEEF to 0x00000010, next cycle read 0x00000010 -> readdata=32'hDEADBEEF; read 0x00000013 -> same word (low bits ignored).
- GPIO: write 32'h000001A5 to 0xFFFF0000 -> gpio_out=8'hA5, readback 32'h000000A5. Set gpio_in=8'h3C at cycle N -> read 0xFFFF0004 returns 8'h3C from cycle N+2, 0 before.
- Timer/irq: write COMPARE=5, CTRL=3, TIMER=0 -> STATUS[0] and irq assert on the edge where timer 5->6. W1C STATUS=1 -> irq deasserts next cycle.
- Wrap and priority: TIMER=32'hFFFFFFFF, enabled -> reads 0 next cycle. Write TIMER=100 while enabled -> reads 100, not 101.
- Errors: write to 0x00001000 (RAM_WORDS=64) -> bus_err=1, RAM unchanged, read there returns 0. W1C STATUS=2 clears it. Coincident miss-write and clear -> bus_err stays 1.
- Async reset: assert reset low between edges with timer running and irq=1 -> gpio_out, irq, bus_err and timer read 0 immediately. RAM data written earlier is still readable after release.
